// File: rtl/game_countdown_timer.sv
// Game-round countdown timer: four BCD digits (MM:SS) decremented on each rising
// edge of the one-second tick, with start/pause/restart/bonus-time control.
module game_countdown_timer #(
    parameter int unsigned START_MIN = 2,
    parameter int unsigned START_SEC = 0,
    parameter int unsigned WARN_SEC  = 10,
    parameter int unsigned BONUS_SEC = 10
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       restart,
    input  logic       add_time,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       warning,
    output logic       expired,
    output logic       time_up
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] PAUSED = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [15:0] START_DIGITS = {4'(START_MIN / 10), 4'(START_MIN % 10),
                                            4'(START_SEC / 10), 4'(START_SEC % 10)};
    localparam logic [3:0]  BONUS_TENS   = 4'(BONUS_SEC / 10);

    logic [1:0]  state, state_nx;
    logic [15:0] digits, digits_nx, work;
    logic        tick_prev, tick_edge;
    logic        expired_nx;
    logic [12:0] total_sec;

    // Digits packed as {min_tens, min_ones, sec_tens, sec_ones}; never called at 00:00.
    function automatic logic [15:0] bcd_dec(input logic [15:0] d);
        logic [3:0] a, b, c, e;
        {a, b, c, e} = d;
        if (e != 4'd0) begin
            e = e - 4'd1;
        end else begin
            e = 4'd9;
            if (c != 4'd0) begin
                c = c - 4'd1;
            end else begin
                c = 4'd5;
                if (b != 4'd0) begin
                    b = b - 4'd1;
                end else begin
                    b = 4'd9;
                    a = a - 4'd1;
                end
            end
        end
        return {a, b, c, e};
    endfunction

    // Bonus is whole tens of seconds, so at most one carry reaches the minutes.
    function automatic logic [15:0] bcd_add(input logic [15:0] d);
        logic [3:0] a, b, c, e, s;
        {a, b, c, e} = d;
        s = c + BONUS_TENS;
        if (s >= 4'd6) begin
            c = s - 4'd6;
            if (b == 4'd9) begin
                b = 4'd0;
                if (a == 4'd9) begin
                    return 16'h9959;
                end
                a = a + 4'd1;
            end else begin
                b = b + 4'd1;
            end
        end else begin
            c = s;
        end
        return {a, b, c, e};
    endfunction

    assign tick_edge = tick & ~tick_prev;

    always_comb begin
        state_nx   = state;
        digits_nx  = digits;
        expired_nx = 1'b0;
        work       = digits;
        if (restart) begin
            state_nx  = IDLE;
            digits_nx = START_DIGITS;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (digits == '0) begin
                            state_nx   = DONE;
                            expired_nx = 1'b1;
                        end else begin
                            state_nx = RUN;
                        end
                    end
                end
                RUN: begin
                    // Bonus applied before the tick so a same-cycle pair nets +BONUS-1.
                    if (add_time) begin
                        work = bcd_add(work);
                    end
                    if (tick_edge && work != '0) begin
                        work = bcd_dec(work);
                    end
                    digits_nx = work;
                    if (tick_edge && work == '0) begin
                        state_nx   = DONE;
                        expired_nx = 1'b1;
                    end else if (pause) begin
                        state_nx = PAUSED;
                    end
                end
                PAUSED: begin
                    if (add_time) begin
                        digits_nx = bcd_add(digits);
                    end
                    if (pause) begin
                        state_nx = RUN;
                    end
                end
                DONE: begin
                    state_nx = DONE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            digits    <= START_DIGITS;
            tick_prev <= 1'b0;
            expired   <= 1'b0;
        end else begin
            state     <= state_nx;
            digits    <= digits_nx;
            tick_prev <= tick;
            expired   <= expired_nx;
        end
    end

    assign {min_tens, min_ones, sec_tens, sec_ones} = digits;

    assign total_sec = 13'(min_tens) * 13'd600 + 13'(min_ones) * 13'd60
                     + 13'(sec_tens) * 13'd10 + 13'(sec_ones);

    assign running = (state == RUN);
    assign time_up = (state == DONE);
    assign warning = ((state == RUN) || (state == PAUSED)) && (WARN_SEC != 0)
                     && (32'(total_sec) <= WARN_SEC);

endmodule

// File: doc/game_countdown_timer.md
Name: game_countdown_timer

Overview:
- Game-round countdown timer driven by the one-second tick pulse from the design's slow-clock generator.
- Holds remaining time as four BCD digits (MM:SS) for the score/HUD drawer.
- Supports start, pause, restart and bonus-time add.
- Flags a low-time warning and raises an expiry pulse and level for the game-state controller.

Parameters:
- START_MIN, 2, initial minutes, 0..99.
- START_SEC, 0, initial seconds, 0..59.
- WARN_SEC, 10, warning asserted when remaining total seconds <= WARN_SEC; 0 disables warning.
- BONUS_SEC, 10, seconds added per add_time; must be a multiple of 10, in 10..50.

Ports:
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- tick  in  1  one-second pulse from the slow-clock generator; may stay high several cycles; only its rising edge counts
- start  in  1  single-cycle request; IDLE -> RUN
- pause  in  1  single-cycle toggle; RUN <-> PAUSED
- restart  in  1  single-cycle; reload start time and go to IDLE from any state
- add_time  in  1  single-cycle; add BONUS_SEC in RUN or PAUSED
- min_tens  out  4  BCD
- min_ones  out  4  BCD
- sec_tens  out  4  BCD, 0..5
- sec_ones  out  4  BCD
- running  out  1  high in RUN
- warning  out  1  low-time flag
- expired  out  1  one-cycle pulse on reaching 00:00
- time_up  out  1  level, high in DONE

Behaviour:
- Clocking: all state is in clk flops.
- Reset: asynchronous, active-low.
  - State IDLE; digits = START_MIN:START_SEC; tick_prev = 0.
  - running, warning, expired and time_up all = 0.
- Edge detect: tick_edge = tick & ~tick_prev, with tick_prev registered every cycle.
  - A tick held high for N cycles yields exactly one tick_edge.
- FSM states: IDLE, RUN, PAUSED, DONE.
  - IDLE: digits frozen, ticks ignored.
    - start with time != 00:00 -> RUN.
    - start with time == 00:00 -> DONE, with expired pulsed.
  - RUN: each tick_edge decrements by one second.
    - If the decrement produces 00:00: -> DONE on the same edge, and expired = 1 for exactly the following cycle.
    - pause -> PAUSED.
  - PAUSED: digits frozen, ticks ignored.
    - pause -> RUN.
    - start is ignored.
  - DONE: digits held at 00:00; time_up = 1.
    - start, pause, add_time and tick are all ignored.
- restart: in any state, reload START digits, -> IDLE, clear expired and time_up. Takes effect on the next edge.
- Priority per cycle: restart > add_time > tick_edge > pause > start.
  - pause and tick_edge together in RUN: the decrement is applied and the state becomes PAUSED.
- BCD decrement with borrow:
  - sec_ones 0 -> 9, borrow into sec_tens.
  - sec_tens 0 -> 5, borrow into min_ones.
  - min_ones 0 -> 9, borrow into min_tens.
  - A decrement is never applied at 00:00.
- add_time (RUN or PAUSED only): sec_tens += BONUS_SEC/10, carrying at 6 into minutes (min_ones carries at 10).
  - Saturates at 99:59: any result above 99:59 is clamped to 99:59.
  - add_time and tick_edge in the same RUN cycle: apply the add first, then decrement. Net is +BONUS_SEC-1 unless saturated; if saturated, 99:58.
- Output timing: digits update on the clock edge where tick_edge/add_time is sampled, and are visible the next cycle.
  - Outputs are registered, or decoded purely from registered state; no combinational path from inputs to outputs.
- running = (state == RUN).
- warning = (state in RUN or PAUSED) and total_seconds <= WARN_SEC, where total_seconds = 60*minutes + seconds, computed from the digits.
- time_up = (state == DONE).
- Digits never leave the legal BCD ranges.

Test Plan:
- Reset, then START_MIN=0, START_SEC=12, WARN_SEC=10: outputs 00:12 and all flags 0. start, then 2 tick pulses -> 00:10, running=1, warning=1 after the 2nd tick.
- Defaults (02:00): start, then 1 tick -> 01:59. Then 60 ticks -> 00:59, with a borrow across every digit checked.
- tick held high for 5 cycles, then low: exactly one decrement. 3 single-cycle ticks -> 3 decrements.
- START 00:02: start, then 2 ticks -> 00:00, expired high for exactly 1 cycle, time_up=1, running=0. Further ticks, start and add_time leave 00:00 and DONE unchanged.
- At 00:05 in RUN: pause, 3 ticks -> still 00:05. add_time -> 00:15. pause, then add_time and tick in the same cycle -> 00:24.
- At 99:55 in RUN: add_time -> 99:59 (saturated). restart asserted at the same time as a tick -> START digits, IDLE, flags 0. Asynchronous resetN mid-RUN -> immediate reset values.
